// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register file write port.
// Each requester owns a one-entry buffer, drained oldest-first with round-robin tie-break.
module regfile_write_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_reg,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_reg,
  input  logic [WIDTH-1:0] req1_data,
  output logic             RegWrite,
  output logic [4:0]       WriteRegister,
  output logic [WIDTH-1:0] WriteData,
  output logic [31:0]      pending
);

  logic [1:0]       r_full;
  logic [4:0]       r_reg  [2];
  logic [WIDTH-1:0] r_data [2];
  logic             r_tie;
  logic             r_older;
  logic             r_rr;

  logic [1:0]       w_valid;
  logic [4:0]       w_in_reg  [2];
  logic [WIDTH-1:0] w_in_data [2];
  logic [1:0]       w_grant;
  logic             w_sel;
  logic [1:0]       w_ready;
  logic [1:0]       w_load;
  logic [1:0]       w_full_d;
  logic             w_tie_d;
  logic             w_older_d;

  assign w_valid      = {req1_valid, req0_valid};
  assign w_in_reg[0]  = req0_reg;
  assign w_in_reg[1]  = req1_reg;
  assign w_in_data[0] = req0_data;
  assign w_in_data[1] = req1_data;

  // Tied entries go by the round-robin pointer, otherwise the older entry wins.
  always_comb begin
    w_grant = 2'b00;
    w_sel   = 1'b0;
    unique case (r_full)
      2'b01: w_grant = 2'b01;
      2'b10: w_grant = 2'b10;
      2'b11: begin
        w_sel   = r_tie ? r_rr : r_older;
        w_grant = w_sel ? 2'b10 : 2'b01;
      end
      default: w_grant = 2'b00;
    endcase
  end

  assign w_ready    = ~r_full | w_grant;
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  always_comb begin
    w_load   = 2'b00;
    w_full_d = 2'b00;
    for (int k = 0; k < 2; k++) begin
      w_load[k]   = w_valid[k] & w_ready[k] & (w_in_reg[k] != 5'd31);
      w_full_d[k] = w_load[k] | (r_full[k] & ~w_grant[k]);
    end
  end

  // r_older names the buffer holding the older entry when both are full.
  always_comb begin
    w_tie_d   = r_tie;
    w_older_d = r_older;
    if (&w_load) begin
      w_tie_d = 1'b1;
    end else if (w_load[0] && w_full_d[1]) begin
      w_tie_d   = 1'b0;
      w_older_d = 1'b1;
    end else if (w_load[1] && w_full_d[0]) begin
      w_tie_d   = 1'b0;
      w_older_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full        <= 2'b00;
      r_tie         <= 1'b0;
      r_older       <= 1'b0;
      r_rr          <= 1'b0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= '0;
      for (int k = 0; k < 2; k++) begin
        r_reg[k]  <= 5'd0;
        r_data[k] <= '0;
      end
    end else begin
      r_full  <= w_full_d;
      r_tie   <= w_tie_d;
      r_older <= w_older_d;
      for (int k = 0; k < 2; k++) begin
        if (w_load[k]) begin
          r_reg[k]  <= w_in_reg[k];
          r_data[k] <= w_in_data[k];
        end
      end
      if (|w_grant) begin
        RegWrite      <= 1'b1;
        WriteRegister <= w_grant[1] ? r_reg[1] : r_reg[0];
        WriteData     <= w_grant[1] ? r_data[1] : r_data[0];
        r_rr          <= w_grant[0];
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  always_comb begin
    pending = 32'd0;
    for (int i = 0; i < 31; i++) begin
      pending[i] = (r_full[0] && (r_reg[0] == 5'(i))) ||
                   (r_full[1] && (r_reg[1] == 5'(i))) ||
                   (RegWrite && (WriteRegister == 5'(i)));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random stimulus for regfile_write_arbiter, checked against a
// timestamp-ordered reference model of the two holding buffers.
module tb_regfile_write_arbiter;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [4:0]   req0_reg, req1_reg;
  logic [W-1:0] req0_data, req1_data;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [W-1:0] WriteData;
  logic [31:0]  pending;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_reg      (req0_reg),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_reg      (req1_reg),
    .req1_data     (req1_data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .pending       (pending)
  );

  // Reference model: each buffer entry carries the cycle number it was filled in.
  bit           m_full [2];
  logic [4:0]   m_reg  [2];
  logic [W-1:0] m_data [2];
  int           m_ts   [2];
  bit           m_rr;
  bit           m_we;
  logic [4:0]   m_wr;
  logic [W-1:0] m_wd;
  int           cyc;
  logic [W-1:0] rf [32];
  int           n_cmp = 0;
  int           n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0;
      m_reg[k]  = 5'd0;
      m_data[k] = '0;
      m_ts[k]   = 0;
    end
    m_rr = 0;
    m_we = 0;
    m_wr = 5'd0;
    m_wd = '0;
  endtask

  function automatic int winner();
    if (m_full[0] && m_full[1]) begin
      if (m_ts[0] < m_ts[1]) return 0;
      if (m_ts[1] < m_ts[0]) return 1;
      return m_rr ? 1 : 0;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic check_all();
    int g;
    logic [31:0] p;
    g = winner();
    p = 32'd0;
    for (int k = 0; k < 2; k++) if (m_full[k]) p[m_reg[k]] = 1'b1;
    if (m_we) p[m_wr] = 1'b1;
    p[31] = 1'b0;
    check("req0_ready", 64'(req0_ready), 64'(!m_full[0] || g == 0));
    check("req1_ready", 64'(req1_ready), 64'(!m_full[1] || g == 1));
    check("RegWrite", 64'(RegWrite), 64'(m_we));
    check("WriteRegister", 64'(WriteRegister), 64'(m_wr));
    check("WriteData", WriteData, m_wd);
    check("pending", 64'(pending), 64'(p));
    if (RegWrite) rf[WriteRegister] = WriteData;
  endtask

  task automatic cycle(input bit v0, input logic [4:0] r0, input logic [W-1:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [W-1:0] d1);
    int g;
    bit acc0, acc1;
    @(negedge clk);
    check_all();
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    g    = winner();
    acc0 = v0 && (!m_full[0] || g == 0);
    acc1 = v1 && (!m_full[1] || g == 1);
    @(posedge clk);
    if (g >= 0) begin
      m_we = 1;
      m_wr = m_reg[g];
      m_wd = m_data[g];
      m_full[g] = 0;
      m_rr = (g == 0);
    end else begin
      m_we = 0;
    end
    if (acc0 && r0 != 5'd31) begin
      m_full[0] = 1; m_reg[0] = r0; m_data[0] = d0; m_ts[0] = cyc;
    end
    if (acc1 && r1 != 5'd31) begin
      m_full[1] = 1; m_reg[1] = r1; m_data[1] = d1; m_ts[1] = cyc;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, '0, 0, 5'd0, '0);
  endtask

  initial begin
    cyc = 1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    model_reset();
    reset = 1'b0;
    req0_valid = 0; req0_reg = 5'd0; req0_data = '0;
    req1_valid = 0; req1_reg = 5'd0; req1_data = '0;

    // Reset values, then idle after release.
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    idle(4);

    // Single write.
    cycle(1, 5'd5, 64'hDEAD_BEEF, 0, 5'd0, '0);
    idle(4);

    // Simultaneous requests, twice.
    cycle(1, 5'd3, 64'h33, 1, 5'd4, 64'h44);
    idle(4);
    cycle(1, 5'd3, 64'h333, 1, 5'd4, 64'h444);
    idle(4);

    // Age ordering: arrange for req1 to win a tie, stalling req0's reg 7 = 0x2.
    cycle(1, 5'd5, 64'h55, 0, 5'd0, '0);
    idle(3);
    cycle(1, 5'd7, 64'h2, 1, 5'd9, 64'h99);
    cycle(0, 5'd0, '0, 1, 5'd7, 64'h1);
    idle(5);
    check("final_reg7", rf[7], 64'h1);

    // Register 31 stream is swallowed.
    for (int i = 0; i < 4; i++) cycle(1, 5'd31, {$urandom, $urandom}, 0, 5'd0, '0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    idle(3);

    // Reset mid-flight with both buffers filling.
    cycle(1, 5'd10, 64'hA, 1, 5'd11, 64'hB);
    #2 reset = 1'b0;
    #1;
    check("rst_RegWrite", 64'(RegWrite), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd1);
    check("rst_ready1", 64'(req1_ready), 64'd1);
    model_reset();
    req0_valid = 0;
    req1_valid = 0;
    #1 reset = 1'b1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
